// File: rtl/polygon_edge_builder.sv
// Turns a gap-delimited vertex stream into closed polygon edges, buffered in a FWFT FIFO with
// registered outputs. Define EDGE_DEGENERATE_FILTER_EN to drop zero-length edges before buffering.
module polygon_edge_builder #(
  parameter int WORLD_BITS = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  vertex_valid_in,
  input  logic [WORLD_BITS-1:0] x_in,
  input  logic [WORLD_BITS-1:0] y_in,
  input  logic                  frame_done_in,
  input  logic                  edge_ready_in,
  output logic                  edge_valid_out,
  output logic [WORLD_BITS-1:0] x0_out,
  output logic [WORLD_BITS-1:0] y0_out,
  output logic [WORLD_BITS-1:0] x1_out,
  output logic [WORLD_BITS-1:0] y1_out,
  output logic                  edge_last_out,
  output logic                  frame_done_out,
  output logic                  overflow_out,
  output logic [1:0]            capture_state_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 4 * WORLD_BITS + 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Encoding is visible on capture_state_out: 0 = no open polygon, 1 = one vertex, 2 = open.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_OPEN  = 2'd2
  } state_t;

  // Handshake: an edge moves downstream on every rising edge where edge_valid_out && edge_ready_in;
  // while valid is high without ready, all edge outputs hold and valid never drops.

  state_t                state;
  logic [WORLD_BITS-1:0] first_x, first_y, prev_x, prev_y;
  logic                  emit_raw, emit;
  logic [WORLD_BITS-1:0] cand_x1, cand_y1;
  logic                  cand_last;
  logic                  pend_valid;
  logic [EW-1:0]         pend_edge;
  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr, rd_ptr_n;
  logic                  fifo_full, fifo_empty, pop, push, fire;
  logic                  done_pending;
  logic [EW-1:0]         head_edge;

  always_comb begin
    emit_raw  = 1'b0;
    cand_x1   = x_in;
    cand_y1   = y_in;
    cand_last = 1'b0;
    case (state)
      ST_ONE, ST_OPEN: begin
        if (vertex_valid_in) begin
          emit_raw = 1'b1;
        end else if (state == ST_OPEN) begin
          emit_raw  = 1'b1;
          cand_x1   = first_x;
          cand_y1   = first_y;
          cand_last = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef EDGE_DEGENERATE_FILTER_EN
  assign emit = emit_raw && !((prev_x == cand_x1) && (prev_y == cand_y1));
`else
  assign emit = emit_raw;
`endif

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = edge_valid_out && edge_ready_in;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push       = pend_valid && (!fifo_full || pop);
  assign rd_ptr_n   = pop ? (rd_ptr + PTR_ONE) : rd_ptr;
  assign fire       = done_pending && (state == ST_EMPTY) && !pend_valid && fifo_empty;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state          <= ST_EMPTY;
      first_x        <= '0;
      first_y        <= '0;
      prev_x         <= '0;
      prev_y         <= '0;
      pend_valid     <= 1'b0;
      pend_edge      <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      edge_valid_out <= 1'b0;
      head_edge      <= '0;
      overflow_out   <= 1'b0;
      done_pending   <= 1'b0;
      frame_done_out <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: if (vertex_valid_in) begin
          first_x <= x_in;
          first_y <= y_in;
          prev_x  <= x_in;
          prev_y  <= y_in;
          state   <= ST_ONE;
        end
        ST_ONE: if (vertex_valid_in) begin
          prev_x <= x_in;
          prev_y <= y_in;
          state  <= ST_OPEN;
        end else begin
          state <= ST_EMPTY;
        end
        ST_OPEN: if (vertex_valid_in) begin
          prev_x <= x_in;
          prev_y <= y_in;
        end else begin
          state <= ST_EMPTY;
        end
        default: state <= ST_EMPTY;
      endcase

      pend_valid <= emit;
      if (emit) pend_edge <= {prev_x, prev_y, cand_x1, cand_y1, cand_last};

      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pend_valid && !push) overflow_out <= 1'b1;

      // Head register looks at the pre-write pointer, so a fresh entry shows one cycle after it lands.
      rd_ptr         <= rd_ptr_n;
      edge_valid_out <= (wr_ptr != rd_ptr_n);
      head_edge      <= mem[rd_ptr_n[AW-1:0]];

      frame_done_out <= fire;
      if (fire) done_pending <= 1'b0;
      else if (frame_done_in) done_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr[AW-1:0]] <= pend_edge;
  end

  assign {x0_out, y0_out, x1_out, y1_out, edge_last_out} = head_edge;
  assign capture_state_out = state;

endmodule
